if_fetch_queue: RTL

// Parametrised instruction-fetch stage. Owns the PC register and issues in-order requests to

---
 rtl/if_fetch_queue_if.sv | 36 +++
 rtl/if_fetch_queue.sv | 122 ++++++++++++
 2 files changed

// File: rtl/if_fetch_queue_if.sv
// Handshake bundle for the instruction-fetch stage.
//   redirect_valid/redirect_pc : PC redirect from branch resolve
//   imem_req_*                 : in-order fetch requests to instruction memory
//   imem_resp_*                : in-order fetch responses
//   id_*                       : fetched {instr, pc, pc+4} toward ID
//   fq_count                   : fetch-queue occupancy
// master = fetch stage, slave = surrounding environment (memory, EX, ID).
interface if_fetch_queue_if #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ILEN     = 32,
  parameter int unsigned FQ_DEPTH = 4
) ();
  logic                          redirect_valid;
  logic [XLEN-1:0]               redirect_pc;
  logic                          imem_req_valid;
  logic                          imem_req_ready;
  logic [XLEN-1:0]               imem_req_addr;
  logic                          imem_resp_valid;
  logic [ILEN-1:0]               imem_resp_data;
  logic                          id_valid;
  logic                          id_ready;
  logic [ILEN-1:0]               id_instr;
  logic [XLEN-1:0]               id_pc;
  logic [XLEN-1:0]               id_pc_plus4;
  logic [$clog2(FQ_DEPTH+1)-1:0] fq_count;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4, fq_count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4, fq_count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests with up
// to MAX_OUTSTANDING in flight, buffers responses in a FQ_DEPTH-entry queue and
// presents the queue head {instr, pc, pc+4} to ID.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : if_fetch_queue_if.master (redirect, imem request/response, ID side, fq_count)
module if_fetch_queue #(
  parameter int unsigned     XLEN            = 64,
  parameter int unsigned     ILEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FQ_DEPTH        = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input logic               clk,
  input logic               reset,
  if_fetch_queue_if.master  bus
);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned QW = $clog2(FQ_DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned SW = $clog2(FQ_DEPTH + MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] pc;

  logic [ILEN-1:0] q_instr [FQ_DEPTH];
  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [QW-1:0]   q_head;
  logic [QW-1:0]   q_tail;
  logic [CW-1:0]   q_count;

  logic [XLEN-1:0] fl_pc [MAX_OUTSTANDING];
  logic [IW-1:0]   fl_head;
  logic [IW-1:0]   fl_tail;

  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   drop;

  logic [SW-1:0]   credit_used;
  logic            req_valid;
  logic            req_fire;
  logic            resp_live;
  logic            id_pop;

  function automatic logic [IW-1:0] fl_next(input logic [IW-1:0] p);
    return (p == IW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit counts queued entries plus live (non-dropped) requests, so every
  // response that will be enqueued already owns a slot.
  always_comb begin
    credit_used = SW'(q_count) + SW'(outstanding) - SW'(drop);
    req_valid   = !reset && !bus.redirect_valid
                  && (outstanding < OW'(MAX_OUTSTANDING))
                  && (credit_used < SW'(FQ_DEPTH));
    req_fire    = req_valid && bus.imem_req_ready;
    resp_live   = bus.imem_resp_valid && (drop == '0) && !bus.redirect_valid;
    id_pop      = (q_count != '0) && bus.id_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
      fl_head     <= '0;
      fl_tail     <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      // The in-flight PC FIFO tracks the memory, so it advances even on redirect.
      if (req_fire)
        fl_tail <= fl_next(fl_tail);
      if (bus.imem_resp_valid)
        fl_head <= fl_next(fl_head);
      outstanding <= outstanding + OW'(req_fire) - OW'(bus.imem_resp_valid);

      if (bus.redirect_valid) begin
        pc      <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        q_head  <= '0;
        q_tail  <= '0;
        q_count <= '0;
        // Everything still in flight after this edge belongs to the old path.
        drop    <= outstanding - OW'(bus.imem_resp_valid);
      end else begin
        if (req_fire)
          pc <= pc + XLEN'(4);
        if (bus.imem_resp_valid && (drop != '0))
          drop <= drop - 1'b1;
        if (resp_live)
          q_tail <= q_tail + 1'b1;
        if (id_pop)
          q_head <= q_head + 1'b1;
        q_count <= q_count + CW'(resp_live) - CW'(id_pop);
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (req_fire)
      fl_pc[fl_tail] <= pc;
    if (resp_live && !reset) begin
      q_instr[q_tail] <= bus.imem_resp_data;
      q_pc[q_tail]    <= fl_pc[fl_head];
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = (q_count != '0);
  assign bus.id_instr       = q_instr[q_head];
  assign bus.id_pc          = q_pc[q_head];
  assign bus.id_pc_plus4    = q_pc[q_head] + XLEN'(4);
  assign bus.fq_count       = q_count;

  a_resp_needs_request: assert property (
    @(posedge clk) disable iff (reset) bus.imem_resp_valid |-> (outstanding != '0)
  );
endmodule
